// File: rtl/rx_tx_pkg.sv
// Shared defaults, pointer-width helper and statistics counter types for the rx/tx relay.
// RX_TX_RELAY_STATS_EN (optional) adds the rx/tx/drop statistics counters.
package rx_tx_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef logic [31:0] stat_cnt_t;
    typedef logic [15:0] drop_cnt_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rx_tx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the relay never exposes an entry it has not written.
module rx_tx_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_tx_relay.sv
// Parametrised rx->tx relay: show-ahead FIFO with ready/valid on both sides, flush, level and sticky ovf.
// Define RX_TX_RELAY_STATS_EN to add the rx_cnt/tx_cnt/drop_cnt statistics outputs.
module rx_tx_relay
    import rx_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rx_dv,
    output logic              rx_rdy,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en,
    input  logic              tx_rdy,
    input  logic              flush,
    output logic [CNT_W-1:0]  level,
    output logic              ovf
`ifdef RX_TX_RELAY_STATS_EN
    ,
    output logic [31:0]       rx_cnt,
    output logic [31:0]       tx_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int               PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              drop;

    // Handshakes are qualified by the registered flags only, so no rx_dv/tx_rdy -> rdy/en path exists.
    assign rx_rdy = (level != FULL);
    assign tx_en  = (level != '0);
    assign push   = rx_dv & rx_rdy & ~flush;
    assign pop    = tx_en & tx_rdy & ~flush;
    assign drop   = rx_dv & ~rx_rdy & ~flush;
    assign txd    = tx_en ? head : '0;

    rx_tx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rxd),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef RX_TX_RELAY_STATS_EN
    // Statistics survive flush; only reset clears them. drop_cnt sticks at all-ones.
    stat_cnt_t rx_cnt_q;
    stat_cnt_t tx_cnt_q;
    drop_cnt_t drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) begin
                rx_cnt_q <= rx_cnt_q + 32'd1;
            end
            if (pop) begin
                tx_cnt_q <= tx_cnt_q + 32'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign rx_cnt   = rx_cnt_q;
    assign tx_cnt   = tx_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_tx_relay.sv
// Directed table-driven bench for rx_tx_relay (DATA_W=8, DEPTH=4), plus hand-written reset sequences.
// Builds with or without RX_TX_RELAY_STATS_EN; the statistics checks are included only when defined.
module tb_rx_tx_relay;

    typedef struct {
        string      name;
        logic       rx_dv;
        logic [7:0] rxd;
        logic       tx_rdy;
        logic       flush;
        logic       exp_rx_rdy;
        logic       exp_tx_en;
        logic [7:0] exp_txd;
        logic [2:0] exp_level;
        logic       exp_ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rxd;
    logic       rx_dv;
    logic       rx_rdy;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_rdy;
    logic       flush;
    logic [2:0] level;
    logic       ovf;
`ifdef RX_TX_RELAY_STATS_EN
    logic [31:0] rx_cnt;
    logic [31:0] tx_cnt;
    logic [15:0] drop_cnt;
`endif

    int   num_vec;
    int   num_mis;
    vec_t vecs[$];

    rx_tx_relay #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_dv    (rx_dv),
        .rx_rdy   (rx_rdy),
        .txd      (txd),
        .tx_en    (tx_en),
        .tx_rdy   (tx_rdy),
        .flush    (flush),
        .level    (level),
        .ovf      (ovf)
`ifdef RX_TX_RELAY_STATS_EN
        ,
        .rx_cnt   (rx_cnt),
        .tx_cnt   (tx_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic dv, input logic [7:0] d,
                                input logic trdy, input logic fl, input logic e_rdy,
                                input logic e_en, input logic [7:0] e_txd,
                                input logic [2:0] e_lvl, input logic e_ovf);
        vec_t v;
        v.name = name;       v.rx_dv = dv;        v.rxd = d;
        v.tx_rdy = trdy;     v.flush = fl;        v.exp_rx_rdy = e_rdy;
        v.exp_tx_en = e_en;  v.exp_txd = e_txd;   v.exp_level = e_lvl;
        v.exp_ovf = e_ovf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic e_rdy, input logic e_en,
                               input logic [7:0] e_txd, input logic [2:0] e_lvl,
                               input logic e_ovf);
        num_vec++;
        if (rx_rdy !== e_rdy || tx_en !== e_en || txd !== e_txd ||
            level !== e_lvl || ovf !== e_ovf) begin
            num_mis++;
            $display("[TB] FAIL %s: got rdy=%b en=%b txd=%02h lvl=%0d ovf=%b, want rdy=%b en=%b txd=%02h lvl=%0d ovf=%b",
                     name, rx_rdy, tx_en, txd, level, ovf, e_rdy, e_en, e_txd, e_lvl, e_ovf);
        end
    endtask

`ifdef RX_TX_RELAY_STATS_EN
    task automatic checkStats(input string name, input logic [31:0] e_rx,
                              input logic [31:0] e_tx, input logic [15:0] e_drop);
        num_vec++;
        if (rx_cnt !== e_rx || tx_cnt !== e_tx || drop_cnt !== e_drop) begin
            num_mis++;
            $display("[TB] FAIL %s: got rx=%0d tx=%0d drop=%0d, want rx=%0d tx=%0d drop=%0d",
                     name, rx_cnt, tx_cnt, drop_cnt, e_rx, e_tx, e_drop);
        end
    endtask
`endif

    task automatic applyStimulus(input vec_t v);
        rx_dv  = v.rx_dv;
        rxd    = v.rxd;
        tx_rdy = v.tx_rdy;
        flush  = v.flush;
        @(posedge clk);
        #1;
        checkOutput(v.name, v.exp_rx_rdy, v.exp_tx_en, v.exp_txd, v.exp_level, v.exp_ovf);
    endtask

    initial begin
        num_vec = 0;
        num_mis = 0;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rxd     = 8'h00;
        tx_rdy  = 1'b0;
        flush   = 1'b0;

        //                name          dv  rxd    trdy fl   rdy en  txd    lvl ovf
        vecs.push_back(mk("single_push", 1, 8'd110, 1, 0,  1, 1, 8'd110, 1, 0));
        vecs.push_back(mk("single_pop",  0, 8'd0,   1, 0,  1, 0, 8'd0,   0, 0));
        vecs.push_back(mk("bp_push0",    1, 8'd110, 0, 0,  1, 1, 8'd110, 1, 0));
        vecs.push_back(mk("bp_push1",    1, 8'd120, 0, 0,  1, 1, 8'd110, 2, 0));
        vecs.push_back(mk("bp_push2",    1, 8'd130, 0, 0,  1, 1, 8'd110, 3, 0));
        vecs.push_back(mk("bp_hold",     0, 8'd0,   0, 0,  1, 1, 8'd110, 3, 0));
        vecs.push_back(mk("bp_pop0",     0, 8'd0,   1, 0,  1, 1, 8'd120, 2, 0));
        vecs.push_back(mk("bp_pop1",     0, 8'd0,   1, 0,  1, 1, 8'd130, 1, 0));
        vecs.push_back(mk("bp_pop2",     0, 8'd0,   1, 0,  1, 0, 8'd0,   0, 0));
        vecs.push_back(mk("fill1",       1, 8'd1,   0, 0,  1, 1, 8'd1,   1, 0));
        vecs.push_back(mk("fill2",       1, 8'd2,   0, 0,  1, 1, 8'd1,   2, 0));
        vecs.push_back(mk("fill3",       1, 8'd3,   0, 0,  1, 1, 8'd1,   3, 0));
        vecs.push_back(mk("fill4",       1, 8'd4,   0, 0,  0, 1, 8'd1,   4, 0));
        vecs.push_back(mk("overflow5",   1, 8'd5,   0, 0,  0, 1, 8'd1,   4, 1));
        vecs.push_back(mk("full_pushpop",1, 8'd6,   1, 0,  1, 1, 8'd2,   3, 1));
        vecs.push_back(mk("drain3",      0, 8'd0,   1, 0,  1, 1, 8'd3,   2, 1));
        vecs.push_back(mk("drain4",      0, 8'd0,   1, 0,  1, 1, 8'd4,   1, 1));
        vecs.push_back(mk("drain_empty", 0, 8'd0,   1, 0,  1, 0, 8'd0,   0, 1));
        vecs.push_back(mk("pre_fl7",     1, 8'd7,   0, 0,  1, 1, 8'd7,   1, 1));
        vecs.push_back(mk("pre_fl8",     1, 8'd8,   0, 0,  1, 1, 8'd7,   2, 1));
        vecs.push_back(mk("pre_fl9",     1, 8'd9,   0, 0,  1, 1, 8'd7,   3, 1));
        vecs.push_back(mk("flush",       1, 8'hAA,  1, 1,  1, 0, 8'd0,   0, 0));
        // Streaming push+pop: after the first word each cycle pops word i-1 and pushes word i.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk($sformatf("wrap%0d", i), 1, 8'(i), 1, 0, 1, 1, 8'(i), 1, 0));
        end
        vecs.push_back(mk("wrap_drain",  0, 8'd0,   1, 0,  1, 0, 8'd0,   0, 0));

        #3;
        checkOutput("in_reset", 1, 0, 8'd0, 0, 0);
        #9;
        rst_n = 1'b1;
        checkOutput("after_reset", 1, 0, 8'd0, 0, 0);
`ifdef RX_TX_RELAY_STATS_EN
        checkStats("stats_reset", 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

`ifdef RX_TX_RELAY_STATS_EN
        // Pushes: 1+3+4+3+10 = 21, pops: 1+3+4+10 = 18, drops: overflow5 and full_pushpop.
        checkStats("stats_run", 32'd21, 32'd18, 16'd2);
`endif

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        applyStimulus(mk("mr_push0", 1, 8'h55, 0, 0, 1, 1, 8'h55, 1, 0));
        applyStimulus(mk("mr_push1", 1, 8'h66, 0, 0, 1, 1, 8'h55, 2, 0));
        applyStimulus(mk("mr_ovfprep",1,8'h67, 0, 0, 1, 1, 8'h55, 3, 0));
        rx_dv = 1'b1;
        rxd   = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 1, 0, 8'd0, 0, 0);
`ifdef RX_TX_RELAY_STATS_EN
        checkStats("stats_mid_reset", 0, 0, 0);
`endif
        #1;
        rst_n = 1'b1;
        rx_dv = 1'b0;
        applyStimulus(mk("resume_push", 1, 8'h77, 1, 0, 1, 1, 8'h77, 1, 0));
        applyStimulus(mk("resume_pop",  0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_mis);
        $finish;
    end

endmodule
